// File: rtl/id_operand_fetch.sv
// Decode-stage operand reader: decodes the IF/ID instruction, reads the 2R/1W register file,
// resolves EX/MEM forwarding and load-use hazards, and registers the result into ID/EX.
module id_operand_fetch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [31:0]       in_pc,

    output logic              re1,
    output logic [ADDR_W-1:0] raddr1,
    input  logic [DATA_W-1:0] rdata1,
    output logic              re2,
    output logic [ADDR_W-1:0] raddr2,
    input  logic [DATA_W-1:0] rdata2,

    input  logic              ex_wreg,
    input  logic              ex_is_load,
    input  logic [ADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,

    input  logic              stall_i,
    input  logic              flush_i,

    output logic              out_valid,
    output logic [31:0]       out_inst,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_reg1,
    output logic [DATA_W-1:0] out_reg2,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_wreg,
    output logic [ADDR_W-1:0] out_waddr,
    output logic              out_is_load,
    output logic              out_is_store
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [5:0]        op;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] imm_lui;

    assign op       = in_inst[31:26];
    assign rs       = ADDR_W'(in_inst[25:21]);
    assign rt       = ADDR_W'(in_inst[20:16]);
    assign rd       = ADDR_W'(in_inst[15:11]);
    assign imm_sext = DATA_W'($signed(in_inst[15:0]));
    assign imm_zext = DATA_W'(in_inst[15:0]);
    assign imm_lui  = DATA_W'({in_inst[15:0], 16'h0000});

    logic              dec_re1;
    logic              dec_re2;
    logic              dec_wreg;
    logic [ADDR_W-1:0] dec_waddr;
    logic [DATA_W-1:0] dec_imm;
    logic              dec_load;
    logic              dec_store;

    always_comb begin
        dec_re1   = 1'b0;
        dec_re2   = 1'b0;
        dec_wreg  = 1'b0;
        dec_waddr = '0;
        dec_imm   = imm_sext;
        dec_load  = 1'b0;
        dec_store = 1'b0;
        case (op)
            OP_RTYPE: begin
                dec_re1   = 1'b1;
                dec_re2   = 1'b1;
                dec_wreg  = 1'b1;
                dec_waddr = rd;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                dec_re1   = 1'b1;
                dec_wreg  = 1'b1;
                dec_waddr = rt;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec_re1   = 1'b1;
                dec_wreg  = 1'b1;
                dec_waddr = rt;
                dec_imm   = imm_zext;
            end
            OP_LUI: begin
                dec_wreg  = 1'b1;
                dec_waddr = rt;
                dec_imm   = imm_lui;
            end
            OP_LW: begin
                dec_re1   = 1'b1;
                dec_wreg  = 1'b1;
                dec_waddr = rt;
                dec_load  = 1'b1;
            end
            OP_SW: begin
                dec_re1   = 1'b1;
                dec_re2   = 1'b1;
                dec_store = 1'b1;
            end
            default: ;
        endcase
        // $0 is hardwired, so a write to it is dropped at decode
        if (dec_waddr == '0) begin
            dec_wreg = 1'b0;
        end
    end

    assign re1    = !rst && in_valid && dec_re1;
    assign re2    = !rst && in_valid && dec_re2;
    assign raddr1 = rst ? '0 : rs;
    assign raddr2 = rst ? '0 : rt;

    // A load in EX has no data yet, so it is never an EX forwarding source
    function automatic logic [DATA_W-1:0] resolve(
        input logic              en,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] rf_data
    );
        logic [DATA_W-1:0] val;
        if (!en || addr == '0) begin
            val = '0;
        end else if (ex_wreg && !ex_is_load && ex_waddr == addr) begin
            val = ex_wdata;
        end else if (mem_wreg && mem_waddr == addr) begin
            val = mem_wdata;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    logic [DATA_W-1:0] opnd1;
    logic [DATA_W-1:0] opnd2;

    assign opnd1 = resolve(re1, rs, rdata1);
    assign opnd2 = resolve(re2, rt, rdata2);

    logic haz1;
    logic haz2;
    logic hazard;
    logic accept;

    assign haz1   = re1 && (rs != '0) && (ex_waddr == rs);
    assign haz2   = re2 && (rt != '0) && (ex_waddr == rt);
    assign hazard = in_valid && ex_wreg && ex_is_load && (ex_waddr != '0) && (haz1 || haz2);

    assign in_ready = !rst && !flush_i && !stall_i && !hazard;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            out_valid    <= 1'b0;
            out_inst     <= '0;
            out_pc       <= '0;
            out_reg1     <= '0;
            out_reg2     <= '0;
            out_imm      <= '0;
            out_wreg     <= 1'b0;
            out_waddr    <= '0;
            out_is_load  <= 1'b0;
            out_is_store <= 1'b0;
        end else if (stall_i) begin
            out_valid <= out_valid;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_inst     <= in_inst;
            out_pc       <= in_pc;
            out_reg1     <= opnd1;
            out_reg2     <= opnd2;
            out_imm      <= dec_imm;
            out_wreg     <= dec_wreg;
            out_waddr    <= dec_waddr;
            out_is_load  <= dec_load;
            out_is_store <= dec_store;
        end else begin
            // bubble: hazard, empty IF/ID, or nothing accepted
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/id_operand_fetch.md
Name: id_operand_fetch

Overview:
- Decode-stage operand reader: the read-side client of the 2R/1W general register file.
- Accepts an instruction from the IF/ID register through a valid/ready handshake and extracts source/destination fields.
- Drives the register file read ports, resolves EX/MEM forwarding, detects load-use hazards, and registers the operands into the ID/EX pipeline register.

Parameters:
DATA_W, 32, register/data width (matches RegBus)
ADDR_W, 5, register address width (matches RegAddrBus)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  IF/ID holds an instruction
in_ready  out  1  block accepts in_inst/in_pc this cycle
in_inst  in  32  instruction word
in_pc  in  32  instruction address
re1  out  1  regfile read enable, port 1 (rs)
raddr1  out  ADDR_W  regfile read address, port 1
rdata1  in  DATA_W  regfile read data, port 1; combinational, same cycle
re2  out  1  regfile read enable, port 2 (rt)
raddr2  out  ADDR_W  regfile read address, port 2
rdata2  in  DATA_W  regfile read data, port 2; combinational, same cycle
ex_wreg, ex_is_load  in  1 each  EX-stage instruction writes a register / is a load
ex_waddr  in  ADDR_W  EX destination
ex_wdata  in  DATA_W  EX result
mem_wreg  in  1  MEM-stage instruction writes a register
mem_waddr  in  ADDR_W  MEM destination
mem_wdata  in  DATA_W  MEM result (load data included)
stall_i  in  1  downstream stall; hold the ID/EX register
flush_i  in  1  kill the current and held instruction
out_valid  out  1  ID/EX register valid
out_inst, out_pc  out  32 each  registered instruction and PC
out_reg1, out_reg2  out  DATA_W each  resolved rs / rt values
out_imm  out  DATA_W  extended immediate
out_wreg  out  1  destination write enable
out_waddr  out  ADDR_W  destination register
out_is_load, out_is_store  out  1 each  memory-class flags

Behaviour:
- Decode (op = inst[31:26]):
  - op 0x00 (R-type): re1=re2=1, wreg=1, waddr=rd.
  - op 0x08–0x0E: re1=1, re2=0, wreg=1, waddr=rt; imm is sign-extended, except 0x0C–0x0E, which are zero-extended.
  - 0x0F (lui): re1=re2=0, wreg=1, waddr=rt, imm={inst[15:0],16'h0}.
  - 0x23 (lw): re1=1, wreg=1, waddr=rt, is_load=1, imm sign-extended.
  - 0x2B (sw): re1=re2=1, wreg=0, is_store=1, imm sign-extended.
  - All other ops: re*=0, wreg=0 (NOP).
  - waddr==0 forces wreg=0.
- Read ports: raddr1=rs, raddr2=rt, driven combinationally from in_inst. re1/re2 are gated with in_valid.
- Forwarding, per operand, when its re=1:
  - Address 0 → 0.
  - Else EX match (ex_wreg & ex_waddr==addr & !ex_is_load) → ex_wdata.
  - Else MEM match → mem_wdata.
  - Else rdata.
  - EX has priority over MEM.
  - A disabled operand resolves to 0.
- Load-use hazard: in_valid & ex_wreg & ex_is_load & ex_waddr!=0, and ex_waddr equals an enabled, non-zero source. Under hazard:
  - in_ready=0.
  - If !stall_i, the next cycle out_valid=0 (bubble).
  - Resolves after one cycle, once the load reaches MEM and forwards through the MEM path.
- in_ready = !stall_i & !hazard. Acceptance = in_valid & in_ready.
- ID/EX register update, in priority order:
  1. rst → every output register 0, including out_valid=0.
  2. flush_i → out_valid=0; other fields don't-care, driven to 0.
  3. stall_i → hold all outputs.
  4. acceptance → load decoded fields, out_valid=1.
  5. otherwise → out_valid=0.
- Latency: 1 cycle from acceptance to out_valid.
- flush_i with stall_i: flush wins. in_ready is forced to 0 during flush.
- Reset mid-operation discards the held instruction. No state survives except the register file itself.
- Combinational read outputs during rst: re1=re2=0, raddr=0, in_ready=0.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 → out_valid=0, all outputs 0, in_ready=0. First post-reset addu $3,$1,$2 (rdata1=5, rdata2=7) → next cycle out_reg1=5, out_reg2=7, out_waddr=3, out_wreg=1.
- Forward priority: addu $4,$2,$2 with ex_waddr=2/ex_wdata=0xAA and mem_waddr=2/mem_wdata=0xBB → out_reg1=out_reg2=0xAA. Drop ex_wreg → both 0xBB.
- Register zero: or $5,$0,$0 with ex_waddr=0, ex_wdata=0xFFFF_FFFF, ex_wreg=1 → out_reg1=out_reg2=0. addiu $0,$1,1 → out_wreg=0.
- Load-use: lw in EX writing $6, sw $6,4($7) presented → in_ready=0, one bubble (out_valid=0). Next cycle mem_waddr=6/mem_wdata=0x1234 → sw accepted, out_reg2=0x1234, out_imm=4, out_is_store=1.
- Stall/flush: with out_valid=1, hold stall_i 3 cycles → outputs constant, in_ready=0. Assert flush_i with stall_i → next cycle out_valid=0.
- Immediates: ori imm 0x8000 → out_imm=0x0000_8000. addiu imm 0x8000 → 0xFFFF_8000. lui 0x1234 → 0x1234_0000, re1=0.
